// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the issue slots,
// the arbiter and the execute-stage ALU.
interface alu_share_arbiter_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             r0_valid;
  logic             r0_ready;
  logic [3:0]       r0_op;
  logic [31:0]      r0_a;
  logic [31:0]      r0_b;
  logic [TAG_W-1:0] r0_tag;

  logic             r1_valid;
  logic             r1_ready;
  logic [3:0]       r1_op;
  logic [31:0]      r1_a;
  logic [31:0]      r1_b;
  logic [TAG_W-1:0] r1_tag;

  logic [3:0]       alu_op;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic [31:0]      alu_result;
  logic             alu_z;
  logic             alu_cout;
  logic             alu_ov;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic             rsp_z;
  logic             rsp_cout;
  logic             rsp_ov;
  logic             rsp_err;
  logic [CNT_W-1:0] ovf_cnt;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r0_tag,
    output r0_ready,
    input  r1_valid, r1_op, r1_a, r1_b, r1_tag,
    output r1_ready,
    output alu_op, alu_in1, alu_in2,
    input  alu_result, alu_z, alu_cout, alu_ov,
    output rsp_valid, rsp_port, rsp_tag, rsp_result,
    output rsp_z, rsp_cout, rsp_ov, rsp_err, ovf_cnt,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r0_tag,
    input  r0_ready,
    output r1_valid, r1_op, r1_a, r1_b, r1_tag,
    input  r1_ready,
    input  alu_op, alu_in1, alu_in2,
    output alu_result, alu_z, alu_cout, alu_ov,
    input  rsp_valid, rsp_port, rsp_tag, rsp_result,
    input  rsp_z, rsp_cout, rsp_ov, rsp_err, ovf_cnt,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational MIPS ALU between two issue slots,
// with a single registered response stage and a saturating overflow counter.
module alu_share_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             last_grant;
  logic             port_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic             z_q;
  logic             cout_q;
  logic             ov_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             any_valid;
  logic             sel;
  logic             can_issue;
  logic             accept;
  logic [3:0]       op;
  logic [31:0]      opa;
  logic [31:0]      opb;
  logic [TAG_W-1:0] tag;
  logic             illegal;
  logic             signed_op;

  // With a single valid port sel follows r1_valid, so an idle cycle selects port 0.
  always_comb begin
    any_valid = bus.r0_valid | bus.r1_valid;
    sel       = (bus.r0_valid & bus.r1_valid) ? ~last_grant : bus.r1_valid;
    can_issue = (state == EMPTY) | bus.rsp_ready;
    accept    = can_issue & any_valid & ~rst;
    op        = sel ? bus.r1_op  : bus.r0_op;
    opa       = sel ? bus.r1_a   : bus.r0_a;
    opb       = sel ? bus.r1_b   : bus.r0_b;
    tag       = sel ? bus.r1_tag : bus.r0_tag;
    illegal   = (op > 4'd9);
    signed_op = (op[3:1] == 3'b000);
  end

  assign bus.r0_ready = accept & ~sel;
  assign bus.r1_ready = accept & sel;

  assign bus.alu_op  = op;
  assign bus.alu_in1 = opa;
  assign bus.alu_in2 = opb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
      z_q        <= 1'b0;
      cout_q     <= 1'b0;
      ov_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        state      <= FULL;
        last_grant <= sel;
        port_q     <= sel;
        tag_q      <= tag;
        if (illegal) begin
          result_q <= '0;
          z_q      <= 1'b0;
          cout_q   <= 1'b0;
          ov_q     <= 1'b0;
          err_q    <= 1'b1;
        end else begin
          result_q <= bus.alu_result;
          z_q      <= bus.alu_z;
          cout_q   <= bus.alu_cout;
          ov_q     <= signed_op & bus.alu_ov;
          err_q    <= 1'b0;
        end
        if (signed_op && bus.alu_ov && (cnt_q != '1))
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if ((state == FULL) && bus.rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_port   = port_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ov     = ov_q;
  assign bus.rsp_err    = err_q;
  assign bus.ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus random test of alu_share_arbiter against a transaction-level
// model; a stand-in ALU answers the arbiter's ALU drive.
module tb_alu_share_arbiter;

  localparam int TAG_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } alu_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  alu_share_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Requester side (held until accepted) and downstream ready
  logic             p_valid [2];
  logic [3:0]       p_op    [2];
  logic [31:0]      p_a     [2];
  logic [31:0]      p_b     [2];
  logic [TAG_W-1:0] p_tag   [2];
  logic             rdy;

  assign bus.r0_valid  = p_valid[0];
  assign bus.r0_op     = p_op[0];
  assign bus.r0_a      = p_a[0];
  assign bus.r0_b      = p_b[0];
  assign bus.r0_tag    = p_tag[0];
  assign bus.r1_valid  = p_valid[1];
  assign bus.r1_op     = p_op[1];
  assign bus.r1_a      = p_a[1];
  assign bus.r1_b      = p_b[1];
  assign bus.r1_tag    = p_tag[1];
  assign bus.rsp_ready = rdy;

  // Raw ALU behaviour; illegal codes return garbage the arbiter must suppress.
  function automatic alu_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_t t;
    logic [32:0] s;
    t = '0;
    s = '0;
    case (op)
      4'd0, 4'd8: begin
        s   = {1'b0, a} + {1'b0, b};
        t.r = s[31:0];
        t.c = s[32];
        t.v = (a[31] == b[31]) && (t.r[31] != a[31]);
      end
      4'd1, 4'd9: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        t.r = s[31:0];
        t.c = s[32];
        t.v = (a[31] != b[31]) && (t.r[31] != a[31]);
      end
      4'd2: t.r = a & b;
      4'd3: t.r = a | b;
      4'd4: t.r = a ^ b;
      4'd5: t.r = ~(a | b);
      4'd6: t.r = a >> b[4:0];
      4'd7: t.r = a << b[4:0];
      default: begin
        t.r = a ^ b ^ 32'hDEAD_BEEF;
        t.c = 1'b1;
        t.v = 1'b1;
      end
    endcase
    t.z = (op > 4'd9) ? 1'b1 : (t.r == 32'd0);
    return t;
  endfunction

  alu_t alu_out;
  assign alu_out        = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);
  assign bus.alu_result = alu_out.r;
  assign bus.alu_z      = alu_out.z;
  assign bus.alu_cout   = alu_out.c;
  assign bus.alu_ov     = alu_out.v;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  bit          m_full;
  int          m_last;
  int          m_cnt;
  logic [31:0] e_res;
  logic        e_z, e_c, e_v, e_err;
  int          e_port;
  logic [TAG_W-1:0] e_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_last = 1; m_cnt = 0;
    e_res = '0; e_z = 0; e_c = 0; e_v = 0; e_err = 0; e_port = 0; e_tag = '0;
  endtask

  task automatic req(input int port, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [TAG_W-1:0] tag);
    p_valid[port] = 1'b1;
    p_op[port]    = op;
    p_a[port]     = a;
    p_b[port]     = b;
    p_tag[port]   = tag;
  endtask

  task automatic check_rsp();
    chk("rsp_valid", bus.rsp_valid, m_full);
    chk("ovf_cnt", bus.ovf_cnt, m_cnt);
    if (m_full) begin
      chk("rsp_result", bus.rsp_result, e_res);
      chk("rsp_z", bus.rsp_z, e_z);
      chk("rsp_cout", bus.rsp_cout, e_c);
      chk("rsp_ov", bus.rsp_ov, e_v);
      chk("rsp_err", bus.rsp_err, e_err);
      chk("rsp_port", bus.rsp_port, e_port);
      chk("rsp_tag", bus.rsp_tag, e_tag);
    end
  endtask

  // One clock cycle: predict grant from the rules, check readys, then the response.
  task automatic step(output int granted);
    bit   can, acc;
    int   g;
    alu_t e;
    #1;
    can = !m_full || rdy;
    if (p_valid[0] && p_valid[1]) g = 1 - m_last;
    else                          g = p_valid[1] ? 1 : 0;
    acc = can && (p_valid[0] || p_valid[1]);
    chk("r0_ready", bus.r0_ready, acc && g == 0);
    chk("r1_ready", bus.r1_ready, acc && g == 1);
    chk("alu_op", bus.alu_op, p_op[g]);
    chk("alu_in1", bus.alu_in1, p_a[g]);
    @(posedge clk);
    #1;
    granted = acc ? g : -1;
    if (acc) begin
      e      = alu_fn(p_op[g], p_a[g], p_b[g]);
      m_full = 1;
      m_last = g;
      e_port = g;
      e_tag  = p_tag[g];
      if (p_op[g] > 4'd9) begin
        e_res = '0; e_z = 0; e_c = 0; e_v = 0; e_err = 1;
      end else begin
        e_res = e.r; e_z = e.z; e_c = e.c; e_err = 0;
        e_v   = (p_op[g] <= 4'd1) && e.v;
      end
      if (p_op[g] <= 4'd1 && e.v && m_cnt < CNT_MAX) m_cnt++;
      p_valid[g] = 1'b0;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    check_rsp();
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  int gnt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; p_tag[i] = '0;
    end
    rdy = 1'b1;
    model_reset();

    // Reset state
    #2;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_ovf_cnt", bus.ovf_cnt, 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_tag", bus.rsp_tag, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Single port add
    req(0, 4'd0, 32'd5, 32'd1, 4'd3);
    step(gnt);
    chk("single_result", bus.rsp_result, 32'd6);
    chk("single_port", bus.rsp_port, 0);
    chk("single_tag", bus.rsp_tag, 3);
    step(gnt);

    // Tie: alternating grants, one response per cycle
    for (int i = 0; i < 6; i++) begin
      if (!p_valid[0]) req(0, 4'd2, $urandom, $urandom, 4'(i));
      if (!p_valid[1]) req(1, 4'd3, $urandom, $urandom, 4'(i + 8));
      step(gnt);
      chk("tie_alternates", gnt, (i % 2 == 0) ? 1 : 0);
    end

    // Backpressure for three cycles, then release accepts in the same cycle
    req(0, 4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 4'd5);
    step(gnt);
    rdy = 1'b0;
    req(0, 4'd7, 32'd1, 32'd4, 4'd6);
    req(1, 4'd6, 32'h8000_0000, 32'd31, 4'd7);
    for (int i = 0; i < 3; i++) step(gnt);
    rdy = 1'b1;
    step(gnt);
    chk("release_accepts", gnt >= 0, 1);
    step(gnt);

    // Signed overflow counts, unsigned does not
    req(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd1);
    step(gnt);
    chk("add_ov", bus.rsp_ov, 1);
    chk("add_ov_cnt", bus.ovf_cnt, 1);
    req(0, 4'd8, 32'h7FFF_FFFF, 32'd1, 4'd2);
    step(gnt);
    chk("addu_no_ov", bus.rsp_ov, 0);
    chk("addu_cnt_same", bus.ovf_cnt, 1);

    // Drive the counter into saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      req(i % 2, (i % 3 == 0) ? 4'd1 : 4'd0, 32'h8000_0000,
          (i % 3 == 0) ? 32'd1 : 32'hFFFF_FFFF, 4'(i));
      step(gnt);
    end
    chk("ovf_saturated", bus.ovf_cnt, CNT_MAX);

    // Illegal op on port 1
    req(1, 4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 4'd9);
    step(gnt);
    chk("illegal_err", bus.rsp_err, 1);
    chk("illegal_result", bus.rsp_result, 0);
    chk("illegal_port", bus.rsp_port, 1);
    step(gnt);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++)
        if (!p_valid[p] && $urandom_range(0, 1) == 1)
          req(p, 4'($urandom_range(0, 15)), rnd32(), rnd32(), 4'($urandom));
      step(gnt);
    end

    // Reset while FULL and stalled
    rdy = 1'b1;
    p_valid[0] = 0; p_valid[1] = 0;
    step(gnt);
    req(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd4);
    step(gnt);
    rdy = 1'b0;
    req(1, 4'd3, 32'd1, 32'd2, 4'd8);
    step(gnt);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_ovf_cnt", bus.ovf_cnt, 0);
    chk("midrst_r1_ready", bus.r1_ready, 0);
    @(posedge clk); #1;
    chk("midrst_no_accept", bus.rsp_valid, 0);
    model_reset();
    rst = 1'b0;
    rdy = 1'b1;
    req(0, 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd10);
    step(gnt);
    chk("post_reset_tie_port0", gnt, 0);
    step(gnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
